// File: rtl/hazard_stall_controller.sv
// Hazard stall controller: load-use stalls, taken-branch flushes and mul/div waits.
// Optional HAZARD_STATS_EN adds saturating flush/bubble counters (ports always exist).
module hazard_stall_controller #(
  parameter int unsigned            REG_ADDR_W    = 4,
  parameter int unsigned            OPCODE_W      = 4,
  parameter logic [OPCODE_W-1:0]    LOAD_OPCODE   = 4'b1000,
  parameter int unsigned            MULDIV_CYCLES = 4,
  parameter int unsigned            STALL_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_op1,
  input  logic [REG_ADDR_W-1:0]  id_op2,
  input  logic                   ex_valid,
  input  logic [OPCODE_W-1:0]    ex_opcode,
  input  logic [REG_ADDR_W-1:0]  ex_dest,
  input  logic                   branch_taken,
  input  logic                   muldiv_start,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   ex_hold,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [STALL_CNT_W-1:0] flush_count,
  output logic [STALL_CNT_W-1:0] bubble_count
);

  typedef enum logic [0:0] {
    RUN         = 1'b0,
    MULDIV_WAIT = 1'b1
  } state_t;

  // The start cycle already counts as one hold cycle, and the exit cycle sees zero.
  localparam logic [3:0] WAIT_INIT = 4'(MULDIV_CYCLES - 2);

  state_t     state, state_nx;
  logic [3:0] wait_cnt, wait_cnt_nx;
  logic       load_use;

  assign load_use = id_valid & ex_valid & (ex_opcode == LOAD_OPCODE) &
                    ((id_op1 == ex_dest) | (id_op2 == ex_dest));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      RUN: begin
        if (muldiv_start) begin
          state_nx    = MULDIV_WAIT;
          wait_cnt_nx = WAIT_INIT;
        end
      end
      MULDIV_WAIT: begin
        if (wait_cnt == '0) begin
          state_nx = RUN;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // Output logic; reset overrides everything so no stall or hold leaks through
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (muldiv_start) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            ex_hold = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        MULDIV_WAIT: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          ex_hold = 1'b1;
          busy    = 1'b1;
        end
        default: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_we && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (ifid_flush && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
      if (idex_bubble && (bubble_count != '1)) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end
  end
`else
  assign flush_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: driver queues hand-computed expectations,
// monitor checks them each cycle on two DUTs (8-bit and 3-bit stall counters).
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_op1 = '0;
  logic [3:0] id_op2 = '0;
  logic       ex_valid = 1'b0;
  logic [3:0] ex_opcode = '0;
  logic [3:0] ex_dest = '0;
  logic       branch_taken = 1'b0;
  logic       muldiv_start = 1'b0;

  logic       pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, busy;
  logic [7:0] stall_count, flush_count, bubble_count;
  logic       pc_we3, ifid_we3, ifid_flush3, idex_bubble3, ex_hold3, busy3;
  logic [2:0] stall_count3, flush_count3, bubble_count3;

  always #5 clk = ~clk;

  hazard_stall_controller #(.STALL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ex_hold(ex_hold), .busy(busy), .stall_count(stall_count),
    .flush_count(flush_count), .bubble_count(bubble_count)
  );

  hazard_stall_controller #(.STALL_CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pc_we(pc_we3), .ifid_we(ifid_we3), .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3),
    .ex_hold(ex_hold3), .busy(busy3), .stall_count(stall_count3),
    .flush_count(flush_count3), .bubble_count(bubble_count3)
  );

  // Expected outputs packed as {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, busy}
  localparam logic [5:0] N  = 6'b110000;
  localparam logic [5:0] LU = 6'b000100;
  localparam logic [5:0] RS = 6'b001100;
  localparam logic [5:0] MS = 6'b000010;
  localparam logic [5:0] MW = 6'b000011;
  localparam logic [5:0] BR = 6'b111000;

  typedef struct {
    logic       rst;
    logic [5:0] outs;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;

  task automatic chk(input string name, input int cyc, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic idv, input logic [3:0] o1, input logic [3:0] o2,
                     input logic exv, input logic [3:0] opc, input logic [3:0] d,
                     input logic b, input logic m, input logic [5:0] eo, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = idv; id_op1 = o1; id_op2 = o2;
    ex_valid = exv; ex_opcode = opc; ex_dest = d; branch_taken = b; muldiv_start = m;
    cyc_no++;
    e.rst = r; e.outs = eo; e.cnt = ec; e.cyc = cyc_no;
    exp_q.push_back(e);
  endtask

  // Monitor: checks every cycle's outputs against the queued expectation
  initial begin : monitor
    int ef8, eb8, ef3, eb3;
    exp_t e;
    ef8 = 0; eb8 = 0; ef3 = 0; eb3 = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_we",       e.cyc, int'(pc_we),       int'(e.outs[5]));
        chk("ifid_we",     e.cyc, int'(ifid_we),     int'(e.outs[4]));
        chk("ifid_flush",  e.cyc, int'(ifid_flush),  int'(e.outs[3]));
        chk("idex_bubble", e.cyc, int'(idex_bubble), int'(e.outs[2]));
        chk("ex_hold",     e.cyc, int'(ex_hold),     int'(e.outs[1]));
        chk("busy",        e.cyc, int'(busy),        int'(e.outs[0]));
        chk("stall_count8", e.cyc, int'(stall_count),  e.cnt);
        chk("stall_count3", e.cyc, int'(stall_count3), (e.cnt > 7) ? 7 : e.cnt);
        chk("pc_we_w3",     e.cyc, int'(pc_we3),       int'(e.outs[5]));
        chk("ex_hold_w3",   e.cyc, int'(ex_hold3),     int'(e.outs[1]));
`ifdef HAZARD_STATS_EN
        chk("flush_count8",  e.cyc, int'(flush_count),   ef8);
        chk("bubble_count8", e.cyc, int'(bubble_count),  eb8);
        chk("flush_count3",  e.cyc, int'(flush_count3),  ef3);
        chk("bubble_count3", e.cyc, int'(bubble_count3), eb3);
        if (e.rst) begin
          ef8 = 0; eb8 = 0; ef3 = 0; eb3 = 0;
        end else begin
          if (e.outs[3]) begin
            if (ef8 < 255) ef8++;
            if (ef3 < 7) ef3++;
          end
          if (e.outs[2]) begin
            if (eb8 < 255) eb8++;
            if (eb3 < 7) eb3++;
          end
        end
`else
        chk("flush_count8",  e.cyc, int'(flush_count),   0);
        chk("bubble_count8", e.cyc, int'(bubble_count),  0);
        chk("flush_count3",  e.cyc, int'(flush_count3),  0);
        chk("bubble_count3", e.cyc, int'(bubble_count3), 0);
`endif
      end
    end
  end

  initial begin : driver
    int guard;
    // Reset with muldiv_start held: no wait may start
    cyc(1,0,0,0,0,4'd0,0,0,1, RS,0);
    cyc(1,0,0,0,0,4'd0,0,0,1, RS,0);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,0);
    // Load-use on op2, then load moves on
    cyc(0,1,0,5,1,4'd8,5,0,0, LU,0);
    cyc(0,1,0,5,1,4'd0,5,0,0, N,1);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,1);
    // R0 is a real register; invalid stages and non-load opcodes do not stall
    cyc(0,1,0,3,1,4'd8,0,0,0, LU,1);
    cyc(0,1,0,3,0,4'd8,0,0,0, N,2);
    cyc(0,0,0,3,1,4'd8,0,0,0, N,2);
    cyc(0,1,0,3,1,4'd9,0,0,0, N,2);
    // Mul/div: four hold cycles, events ignored during the wait
    cyc(0,0,0,0,0,4'd0,0,0,1, MS,2);
    cyc(0,0,0,0,0,4'd0,0,0,0, MW,3);
    cyc(0,1,7,7,1,4'd8,7,1,1, MW,4);
    cyc(0,0,0,0,0,4'd0,0,0,0, MW,5);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,6);
    // Branch alone, then priority against load-use and mul/div
    cyc(0,0,0,0,0,4'd0,0,1,0, BR,6);
    cyc(0,1,2,9,1,4'd8,2,1,0, LU,6);
    cyc(0,1,2,9,1,4'd0,2,1,0, BR,7);
    cyc(0,1,2,9,1,4'd8,2,1,1, MS,7);
    cyc(0,0,0,0,0,4'd0,0,0,0, MW,8);
    // Reset in the second wait cycle aborts the wait
    cyc(1,0,0,0,0,4'd0,0,0,0, RS,9);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,0);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,0);
    // Ten stalls: 3-bit counter saturates at 7
    for (int i = 0; i < 10; i++) begin
      cyc(0,1,4,6,1,4'd8,6,0,0, LU,i);
    end
    cyc(0,0,0,0,0,4'd0,0,0,0, N,10);
    cyc(0,0,0,0,0,4'd0,0,0,0, N,10);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline-control block that acts on the hazards the register forwarding unit cannot resolve by forwarding. Forwarding turns hazards into mux selects; this block turns them into stalls, bubbles and flushes.
- Sits beside the ID/EX boundary of the 5-stage datapath. It drives PC write enable, IF/ID write/flush, the ID/EX bubble and the EX hold.
- Handles three cases: load-use stalls, taken-branch flushes, and multi-cycle multiply/divide waits. It also keeps a saturating stall counter.

Parameters:
- REG_ADDR_W, 4, register-address width.
- OPCODE_W, 4, opcode width.
- LOAD_OPCODE, 4'b1000, opcode of a load in EX.
- MULDIV_CYCLES, 4, total stall cycles for mul/div (legal range 2..15).
- STALL_CNT_W, 8, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_op1  in  REG_ADDR_W  first source register in ID.
- id_op2  in  REG_ADDR_W  second source register in ID.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_opcode  in  OPCODE_W  opcode in EX.
- ex_dest  in  REG_ADDR_W  destination register in EX.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- muldiv_start  in  1  first EX cycle of a mul/div; single-cycle pulse.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- ex_hold  out  1  freeze EX/MEM inputs; EX result not yet valid.
- busy  out  1  state is MULDIV_WAIT.
- stall_count  out  STALL_CNT_W  cycles with pc_we=0, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Control outputs are combinational from state and current inputs; stall_count is registered.
- While rst=1:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, ex_hold=0, busy=0.
  - On the edge: state<=RUN, wait counter<=0, stall_count<=0.
  - Reset arriving mid MULDIV_WAIT aborts the wait; no pending stall survives.
- States: RUN, MULDIV_WAIT. Wait counter is 4 bits.
- Definition: load_use = id_valid & ex_valid & (ex_opcode==LOAD_OPCODE) & ((id_op1==ex_dest) | (id_op2==ex_dest)).
  - All 16 registers are real; there is no R0 exemption.
- RUN, evaluated in priority order:
  1. muldiv_start=1:
     - pc_we=0, ifid_we=0, idex_bubble=0, ex_hold=1.
     - next state MULDIV_WAIT, counter<=MULDIV_CYCLES-2.
  2. Else load_use=1:
     - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
     - Stays in RUN. The load advances to MEM, so the condition clears the next cycle; exactly one bubble.
  3. Else branch_taken=1:
     - pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=0.
  4. Else (normal): pc_we=1, ifid_we=1, all others 0.
- Simultaneous events:
  - A branch_taken that loses to load_use or muldiv is ignored that cycle. The branch stays held in ID and re-asserts later.
- MULDIV_WAIT:
  - pc_we=0, ifid_we=0, ex_hold=1, idex_bubble=0, ifid_flush=0, busy=1.
  - load_use, branch_taken and muldiv_start are ignored.
  - Counter decrements each cycle. When counter==0 on an edge, next state is RUN.
  - Total cycles with ex_hold=1 = MULDIV_CYCLES, counting the start cycle.
- stall_count:
  - +1 on every non-reset cycle with pc_we=0.
  - Holds at all-ones; never wraps.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs flush_count and bubble_count, each STALL_CNT_W wide, saturating.
  - flush_count increments on cycles with ifid_flush=1 and rst=0. bubble_count increments on cycles with idex_bubble=1 and rst=0.
  - Both clear on reset.
- Undefined:
  - Ports are still present but tied to 0.
  - No counter registers are synthesized.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with muldiv_start=1 -> pc_we=0, ifid_flush=1, idex_bubble=1, busy=0; after release stall_count=0 and state RUN.
2. Load-use: ex_opcode=4'b1000, ex_valid=1, ex_dest=5, id_op2=5, id_valid=1 for one cycle, then ex_opcode=NOP -> exactly one cycle of pc_we=0 and idex_bubble=1; stall_count=1.
3. Mul/div with MULDIV_CYCLES=4: pulse muldiv_start -> ex_hold=1 and pc_we=0 for exactly 4 cycles, busy=1 for cycles 2-4, then RUN with pc_we=1; stall_count=4.
4. Priority: load_use=1 and branch_taken=1 together -> ifid_flush=0, idex_bubble=1; next cycle with branch_taken=1 only -> ifid_flush=1, pc_we=1.
5. Reset mid-wait: assert rst in the 2nd MULDIV_WAIT cycle -> next cycle state RUN, busy=0, and no further ex_hold.
6. Saturation with STALL_CNT_W=3: 10 load-use cycles -> stall_count holds at 7. With HAZARD_STATS_EN, bubble_count=7.
